// File: rtl/cordic_sched_pkg.sv
// rtl/cordic_sched_pkg.sv - shared types and constants for the CORDIC engine scheduler
//
// Purpose: FSM state encoding, CORDIC mode encodings and default operand
// sizes used by cordic_engine_sched and its round-robin arbiter.
// Ports: none (package).

package cordic_sched_pkg;

  localparam int DEF_DATA_WIDTH = 20;
  localparam int DEF_ITER       = 12;

  localparam logic MODE_VEC = 1'b0;
  localparam logic MODE_ROT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin one-hot grant selection
//
// Purpose: picks the first set request at or above the priority pointer,
// wrapping around to the lowest set request below it.
// Ports:
//   req_i   [N-1:0]  request vector
//   ptr_i   [PW-1:0] index of the highest-priority requester
//   grant_o [N-1:0]  one-hot grant, zero when no request is set

module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  logic [N-1:0] req_hi;
  logic         found_hi;
  logic         found_lo;

  // Two-pass priority search: first among requesters at/above the pointer,
  // then fall back to the whole vector (which covers the wrapped part).
  always_comb begin
    req_hi   = '0;
    grant_o  = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int k = 0; k < N; k++) begin
      req_hi[k] = req_i[k] && (k >= int'(ptr_i));
    end
    for (int k = 0; k < N; k++) begin
      if (!found_hi && req_hi[k]) begin
        grant_o[k] = 1'b1;
        found_hi   = 1'b1;
      end
    end
    if (!found_hi) begin
      for (int k = 0; k < N; k++) begin
        if (!found_lo && req_i[k]) begin
          grant_o[k] = 1'b1;
          found_lo   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cordic_engine_sched.sv
// rtl/cordic_engine_sched.sv - shares one CORDIC engine among NUM_REQ requesters
//
// Purpose: round-robin job scheduler in front of a single CORDIC engine.
// Vectoring jobs store their direction word per requester; rotation jobs
// reuse it and are only eligible once a valid word is stored. One job is
// in flight at a time (IDLE -> ISSUE -> WAIT -> RESP).
// Optional build macro CORDIC_SCHED_TIMEOUT_EN adds a WAIT watchdog that
// aborts the job after TIMEOUT cycles with rsp_err=1 and zero results.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_mode    per-requester handshake and mode
//   req_x, req_y                    packed operands, slice i = requester i
//   dir_clr                         per-requester direction word invalidate
//   eng_start/eng_mode/eng_x/eng_y/eng_dir   job issue to the engine
//   eng_done/eng_x_o/eng_y_o/eng_dir_o       engine results
//   rsp_valid/rsp_ready/rsp_id/rsp_x/rsp_y/rsp_err   response stream

module cordic_engine_sched
  import cordic_sched_pkg::*;
#(
  parameter int  NUM_REQ    = 4,
  parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int  ITER       = DEF_ITER,
  parameter int  TIMEOUT    = 64,
  localparam int IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_mode,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_x,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_y,
  input  logic [NUM_REQ-1:0]            dir_clr,
  output logic                          eng_start,
  output logic                          eng_mode,
  output logic [DATA_WIDTH-1:0]         eng_x,
  output logic [DATA_WIDTH-1:0]         eng_y,
  output logic [ITER-1:0]               eng_dir,
  input  logic                          eng_done,
  input  logic [DATA_WIDTH-1:0]         eng_x_o,
  input  logic [DATA_WIDTH-1:0]         eng_y_o,
  input  logic [ITER-1:0]               eng_dir_o,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [IDW-1:0]                rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_x,
  output logic [DATA_WIDTH-1:0]         rsp_y,
  output logic                          rsp_err
);

  sched_state_e state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;

  logic [NUM_REQ-1:0] dir_vld_q;
  logic [ITER-1:0]    dir_reg_q [NUM_REQ];

  logic [IDW-1:0]        job_id_q;
  logic                  eng_mode_q;
  logic [DATA_WIDTH-1:0] eng_x_q, eng_y_q;
  logic [ITER-1:0]       eng_dir_q;

  logic [IDW-1:0]        rsp_id_q;
  logic [DATA_WIDTH-1:0] rsp_x_q, rsp_y_q;

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [IDW-1:0]        grant_idx;
  logic                  grant_mode;
  logic [DATA_WIDTH-1:0] grant_x, grant_y;
  logic [ITER-1:0]       grant_dir;

  logic grant_fire;
  logic done_fire;
  logic timeout_fire;

  // Rotation without a stored direction word is simply not a candidate,
  // so it can never hold up the other requesters.
  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = req_valid[k] && ((req_mode[k] == MODE_VEC) || dir_vld_q[k]);
    end
  end

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (IDW)
  ) u_rr_arbiter (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .grant_o (grant)
  );

  // One-hot grant to index and operand mux; vectoring jobs issue a zero word.
  always_comb begin
    grant_idx  = '0;
    grant_mode = MODE_VEC;
    grant_x    = '0;
    grant_y    = '0;
    grant_dir  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) begin
        grant_idx  = IDW'(k);
        grant_mode = req_mode[k];
        grant_x    = req_x[k*DATA_WIDTH +: DATA_WIDTH];
        grant_y    = req_y[k*DATA_WIDTH +: DATA_WIDTH];
        grant_dir  = (req_mode[k] == MODE_ROT) ? dir_reg_q[k] : '0;
      end
    end
  end

`ifdef CORDIC_SCHED_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT + 1);

  logic [WDW-1:0] wd_q;
  logic           rsp_err_q;

  assign timeout_fire = (state_q == ST_WAIT) && !eng_done && (wd_q == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q      <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wd_q <= (state_q == ST_WAIT) ? wd_q + WDW'(1) : '0;
      if (done_fire) begin
        rsp_err_q <= 1'b0;
      end else if (timeout_fire) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout_fire = 1'b0;
  assign rsp_err      = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_fire = 1'b0;
    done_fire  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|eligible) begin
          grant_fire = 1'b1;
          state_d    = ST_ISSUE;
          ptr_d      = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          done_fire = 1'b1;
          state_d   = ST_RESP;
        end else if (timeout_fire) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_id_q   <= '0;
      eng_mode_q <= MODE_VEC;
      eng_x_q    <= '0;
      eng_y_q    <= '0;
      eng_dir_q  <= '0;
      rsp_id_q   <= '0;
      rsp_x_q    <= '0;
      rsp_y_q    <= '0;
      dir_vld_q  <= '0;
      for (int k = 0; k < NUM_REQ; k++) begin
        dir_reg_q[k] <= '0;
      end
    end else begin
      if (grant_fire) begin
        job_id_q   <= grant_idx;
        eng_mode_q <= grant_mode;
        eng_x_q    <= grant_x;
        eng_y_q    <= grant_y;
        eng_dir_q  <= grant_dir;
      end
      // A watchdog abort reports zero results for the same requester.
      if (done_fire || timeout_fire) begin
        rsp_id_q <= job_id_q;
        rsp_x_q  <= done_fire ? eng_x_o : '0;
        rsp_y_q  <= done_fire ? eng_y_o : '0;
      end
      // The clear is written last so it overrides a same-cycle store.
      for (int k = 0; k < NUM_REQ; k++) begin
        if (done_fire && (eng_mode_q == MODE_VEC) && (job_id_q == IDW'(k))) begin
          dir_reg_q[k] <= eng_dir_o;
          dir_vld_q[k] <= 1'b1;
        end
        if (dir_clr[k]) begin
          dir_vld_q[k] <= 1'b0;
        end
      end
    end
  end

  // Gated by rst_n so the accept stays low while reset is held.
  assign req_ready = (grant_fire && rst_n) ? grant : '0;
  assign eng_start = (state_q == ST_ISSUE);
  assign eng_mode  = eng_mode_q;
  assign eng_x     = eng_x_q;
  assign eng_y     = eng_y_q;
  assign eng_dir   = eng_dir_q;
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_x     = rsp_x_q;
  assign rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_cordic_engine_sched.sv
// tb/tb_cordic_engine_sched.sv - randomized self-checking bench for cordic_engine_sched

module tb_cordic_engine_sched;

  localparam int N  = 4;
  localparam int DW = 20;
  localparam int IT = 12;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid, req_ready, req_mode, dir_clr;
  logic [N*DW-1:0] req_x, req_y;
  logic            eng_start, eng_mode, eng_done;
  logic [DW-1:0]   eng_x, eng_y, eng_x_o, eng_y_o;
  logic [IT-1:0]   eng_dir, eng_dir_o;
  logic            rsp_valid, rsp_ready, rsp_err;
  logic [1:0]      rsp_id;
  logic [DW-1:0]   rsp_x, rsp_y;

  always #5 clk = ~clk;

  cordic_engine_sched #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .ITER       (IT),
    .TIMEOUT    (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_mode  (req_mode),
    .req_x     (req_x),
    .req_y     (req_y),
    .dir_clr   (dir_clr),
    .eng_start (eng_start),
    .eng_mode  (eng_mode),
    .eng_x     (eng_x),
    .eng_y     (eng_y),
    .eng_dir   (eng_dir),
    .eng_done  (eng_done),
    .eng_x_o   (eng_x_o),
    .eng_y_o   (eng_y_o),
    .eng_dir_o (eng_dir_o),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_x     (rsp_x),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: stored direction words, their valid flags, RR pointer.
  logic [IT-1:0] m_dir [N];
  logic [N-1:0]  m_vld;
  int            m_ptr;
  bit            keep_valid;
  int            obs_grant;
  logic          seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i] && (req_mode[i] == 1'b0 || m_vld[i])) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_vld = '0;
    m_ptr = 0;
    for (int i = 0; i < N; i++) m_dir[i] = '0;
  endtask

  task automatic set_req(input int i, input logic m, input logic [DW-1:0] x, input logic [DW-1:0] y);
    req_valid[i]       = 1'b1;
    req_mode[i]        = m;
    req_x[i*DW +: DW]  = x;
    req_y[i*DW +: DW]  = y;
  endtask

  task automatic check_zero(input string tag);
    check(tag, {req_ready, eng_start, eng_mode, rsp_valid, rsp_err, rsp_id}, 0);
    check(tag, {eng_x, eng_y}, 0);
    check(tag, {rsp_x, rsp_y}, 0);
    check(tag, eng_dir, 0);
  endtask

  // Called at a negedge while the DUT is idle with requests already driven.
  task automatic run_job(input int lat, input int hold, input logic [N-1:0] clr, input logic [IT-1:0] rd);
    int            g;
    logic          m;
    logic [DW-1:0] ex, ey, rx, ry;
    logic [IT-1:0] ed;
    g = pick();
    #1;
    obs_grant = -1;
    for (int i = 0; i < N; i++) if (req_ready[i]) obs_grant = i;
    check("grant", req_ready, (g < 0) ? 0 : (1 << g));
    if (g < 0) return;
    m     = req_mode[g];
    ex    = req_x[g*DW +: DW];
    ey    = req_y[g*DW +: DW];
    ed    = m ? m_dir[g] : '0;
    m_ptr = (g + 1) % N;
    rx    = DW'($urandom);
    ry    = DW'($urandom);
    @(negedge clk);
    if (!keep_valid) req_valid[g] = 1'b0;
    #1;
    check("eng_start", eng_start, 1);
    check("eng_mode", eng_mode, m);
    check("eng_x", eng_x, ex);
    check("eng_y", eng_y, ey);
    check("eng_dir", eng_dir, ed);
    check("ready_busy", req_ready, 0);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      check("wait_quiet", {eng_start, rsp_valid}, 0);
      if (c == lat - 1) begin
        eng_done  = 1'b1;
        eng_x_o   = rx;
        eng_y_o   = ry;
        eng_dir_o = rd;
        dir_clr   = clr;
      end
    end
    @(negedge clk);
    eng_done = 1'b0;
    dir_clr  = '0;
    if (m == 1'b0) begin
      m_dir[g] = rd;
      m_vld[g] = 1'b1;
    end
    m_vld = m_vld & ~clr;
    for (int c = 0; c <= hold; c++) begin
      #1;
      check("rsp_valid", rsp_valid, 1);
      check("rsp_id", rsp_id, g);
      check("rsp_x", rsp_x, rx);
      check("rsp_y", rsp_y, ry);
      check("rsp_err", rsp_err, 0);
      check("ready_resp", req_ready, 0);
      if (c == hold) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int g;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_mode   = '0;
    req_x      = '0;
    req_y      = '0;
    dir_clr    = '0;
    eng_done   = 1'b0;
    eng_x_o    = '0;
    eng_y_o    = '0;
    eng_dir_o  = '0;
    rsp_ready  = 1'b0;
    keep_valid = 1'b0;
    seen       = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    // Fairness: all four vectoring requests held continuously.
    keep_valid = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, DW'($urandom), DW'($urandom));
    for (int k = 0; k < 5; k++) begin
      run_job(2, 0, '0, IT'($urandom));
      check("rr_order", obs_grant, k % N);
    end
    keep_valid = 1'b0;
    req_valid  = '0;

    // Invalidate every stored word.
    dir_clr = '1;
    @(negedge clk);
    dir_clr = '0;
    m_vld   = '0;

    // Vectoring stores 0xA5A, rotation then reuses it.
    set_req(0, 1'b0, 20'h01000, 20'h00800);
    run_job(4, 0, '0, 12'hA5A);
    set_req(0, 1'b1, DW'($urandom), DW'($urandom));
    run_job(3, 0, '0, IT'($urandom));

    // Rotation without a word is skipped while a vectoring job is served.
    set_req(1, 1'b1, DW'($urandom), DW'($urandom));
    set_req(2, 1'b0, DW'($urandom), DW'($urandom));
    run_job(2, 0, '0, IT'($urandom));
    run_job(2, 0, '0, IT'($urandom));
    @(negedge clk);
    req_valid = '0;

    // Backpressure for 10 cycles, next grant right after the accept.
    set_req(3, 1'b0, DW'($urandom), DW'($urandom));
    set_req(2, 1'b0, DW'($urandom), DW'($urandom));
    run_job(1, 10, '0, IT'($urandom));
    run_job(2, 0, '0, IT'($urandom));

    // Clear coinciding with the vectoring write wins.
    set_req(0, 1'b0, DW'($urandom), DW'($urandom));
    run_job(2, 0, 4'b0001, IT'($urandom));
    set_req(0, 1'b1, DW'($urandom), DW'($urandom));
    run_job(1, 0, '0, IT'($urandom));
    @(negedge clk);
    req_valid = '0;

    // Reset while waiting on the engine, then a stale eng_done.
    set_req(3, 1'b0, DW'($urandom), DW'($urandom));
    g = pick();
    #1;
    check("grant_rst", req_ready, 1 << g);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("reset_wait");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    eng_done = 1'b1;
    eng_x_o  = DW'($urandom);
    @(negedge clk);
    eng_done = 1'b0;
    seen     = 1'b0;
    repeat (3) begin
      #1;
      seen = seen | rsp_valid;
      @(negedge clk);
    end
    check("late_done", seen, 0);

    // Watchdog.
    set_req(1, 1'b0, DW'($urandom), DW'($urandom));
    g = pick();
    m_ptr = (g + 1) % N;
    #1;
    check("grant_wd", req_ready, 1 << g);
    @(negedge clk);
    req_valid = '0;
    seen      = 1'b0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("wd_early", seen, 0);
    @(negedge clk);
    check("wd_valid", rsp_valid, 1);
    check("wd_err", rsp_err, 1);
    check("wd_xy", {rsp_x, rsp_y}, 0);
    check("wd_id", rsp_id, 1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1, 1'b1, DW'($urandom), DW'($urandom));
    run_job(1, 0, '0, IT'($urandom));
    @(negedge clk);
    req_valid = '0;
`else
    repeat (100) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("wd_none", seen, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
`endif

    // Randomized traffic against the model.
    for (int j = 0; j < 60; j++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1)
          set_req(i, 1'($urandom_range(0, 1)), DW'($urandom), DW'($urandom));
      end
      if (pick() < 0) set_req(int'($urandom_range(0, N - 1)), 1'b0, DW'($urandom), DW'($urandom));
      run_job(int'($urandom_range(1, 6)), int'($urandom_range(0, 3)),
              ($urandom_range(0, 3) == 0) ? N'($urandom) : '0, IT'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
